// File: rtl/loteria_n.sv
// loteria_n: digit-entry lottery ticket checker.
//   The user keys in DIGITS BCD digits, can delete the last digit, and submits
//   the ticket. The ticket is compared one digit per cycle against SECRET, a
//   prize tier is latched, and after MAX_TRIES tickets the block locks until
//   reset.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous reset, active low
//   num        - BCD digit to enter
//   insert     - level input; a rising edge enters num
//   del        - level input; a rising edge removes the last entered digit
//   finish     - level input; a rising edge submits / acknowledges a result
//   digits     - entered digits, first entered in the MS nibble, rest 0
//   count      - number of digits entered
//   state      - FSM state code (ENTRY=0 READY=1 CHECK=2 RESULT=3 LOCKED=4)
//   prize      - 0 none, 1 jackpot, 2 second, 3 third
//   win        - high while a nonzero prize is shown
//   err        - one-cycle pulse on a rejected input
//   tries_left - tickets remaining
module loteria_n #(
    parameter int                    DIGITS    = 5,
    parameter logic [4*DIGITS-1:0]   SECRET    = 20'h50967,
    parameter int                    MAX_TRIES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            num,
    input  logic                  insert,
    input  logic                  del,
    input  logic                  finish,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            count,
    output logic [2:0]            state,
    output logic [1:0]            prize,
    output logic                  win,
    output logic                  err,
    output logic [3:0]            tries_left
);

    localparam logic [2:0] ENTRY  = 3'd0;
    localparam logic [2:0] READY  = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] RESULT = 3'd3;
    localparam logic [2:0] LOCKED = 3'd4;

    localparam int HW = $clog2(DIGITS + 1);

    logic          ins_q, del_q, fin_q;
    // armed stays low for the first cycle after reset so that a level already
    // high at release is sampled into the edge registers, not acted upon.
    logic          armed;
    logic          ins_e, del_e, fin_e;
    logic [HW-1:0] hits, hits_nx;
    logic [2:0]    idx;
    logic          dig_eq;
    logic [1:0]    prize_nx;

    assign ins_e = armed & insert & ~ins_q;
    assign del_e = armed & del    & ~del_q;
    assign fin_e = armed & finish & ~fin_q;

    // Digit under test this CHECK cycle; position 0 is the MS nibble.
    always_comb begin
        dig_eq = 1'b0;
        for (int p = 0; p < DIGITS; p++)
            if (p == int'(idx))
                dig_eq = (digits[4*(DIGITS-1-p) +: 4] == SECRET[4*(DIGITS-1-p) +: 4]);
    end

    assign hits_nx = hits + HW'(dig_eq);

    // Tier from the final hit total, including the last digit compared.
    always_comb begin
        prize_nx = 2'd0;
        if (hits_nx == HW'(DIGITS))          prize_nx = 2'd1;
        else if (hits_nx == HW'(DIGITS - 1)) prize_nx = 2'd2;
        else if (hits_nx == HW'(DIGITS - 2)) prize_nx = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ins_q      <= 1'b0;
            del_q      <= 1'b0;
            fin_q      <= 1'b0;
            armed      <= 1'b0;
            state      <= ENTRY;
            digits     <= '0;
            count      <= '0;
            prize      <= '0;
            win        <= 1'b0;
            err        <= 1'b0;
            tries_left <= 4'(MAX_TRIES);
            hits       <= '0;
            idx        <= '0;
        end else begin
            ins_q <= insert;
            del_q <= del;
            fin_q <= finish;
            armed <= 1'b1;
            err   <= 1'b0;
            case (state)
                ENTRY, READY: begin
                    // del wins over a simultaneous insert (and finish)
                    if (del_e) begin
                        if (count == 4'd0) begin
                            err <= 1'b1;
                        end else begin
                            for (int p = 0; p < DIGITS; p++)
                                if (p == int'(count) - 1)
                                    digits[4*(DIGITS-1-p) +: 4] <= 4'd0;
                            count <= count - 4'd1;
                            state <= ENTRY;
                        end
                    end else if (ins_e) begin
                        if (num > 4'd9) begin
                            err <= 1'b1;
                        end else if (count < 4'(DIGITS)) begin
                            for (int p = 0; p < DIGITS; p++)
                                if (p == int'(count))
                                    digits[4*(DIGITS-1-p) +: 4] <= num;
                            count <= count + 4'd1;
                            if (count == 4'(DIGITS - 1))
                                state <= READY;
                        end
                    end else if (fin_e) begin
                        if (state == ENTRY) begin
                            err <= 1'b1;
                        end else begin
                            state <= CHECK;
                            hits  <= '0;
                            idx   <= '0;
                        end
                    end
                end
                CHECK: begin
                    hits <= hits_nx;
                    idx  <= idx + 3'd1;
                    if (idx == 3'(DIGITS - 1)) begin
                        state <= RESULT;
                        prize <= prize_nx;
                        win   <= (prize_nx != 2'd0);
                        if (tries_left != 4'd0)
                            tries_left <= tries_left - 4'd1;
                    end
                end
                RESULT: begin
                    if (fin_e) begin
                        digits <= '0;
                        count  <= '0;
                        prize  <= '0;
                        win    <= 1'b0;
                        state  <= (tries_left != 4'd0) ? ENTRY : LOCKED;
                    end
                end
                LOCKED: begin
                    if (ins_e || del_e || fin_e)
                        err <= 1'b1;
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_loteria_n.sv
// Directed bench for loteria_n with DIGITS=5, SECRET=50967, MAX_TRIES=3.
module tb_loteria_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  num;
    logic        insert, del, finish;
    logic [19:0] digits;
    logic [3:0]  count;
    logic [2:0]  state;
    logic [1:0]  prize;
    logic        win, err;
    logic [3:0]  tries_left;

    int   total = 0;
    int   bad   = 0;
    logic err_seen;

    loteria_n #(.DIGITS(5), .SECRET(20'h50967), .MAX_TRIES(3)) dut (
        .clk(clk), .reset(reset), .num(num), .insert(insert), .del(del),
        .finish(finish), .digits(digits), .count(count), .state(state),
        .prize(prize), .win(win), .err(err), .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each press raises the level for one cycle; err_seen holds err as it
    // stood right after the edge was acted on.
    task automatic press_ins(input logic [3:0] n);
        num = n; insert = 1'b1; step; err_seen = err; insert = 1'b0; step;
    endtask
    task automatic press_del;
        del = 1'b1; step; err_seen = err; del = 1'b0; step;
    endtask
    task automatic press_fin;
        finish = 1'b1; step; err_seen = err; finish = 1'b0; step;
    endtask
    task automatic press_both(input logic [3:0] n);
        num = n; insert = 1'b1; del = 1'b1; step; err_seen = err;
        insert = 1'b0; del = 1'b0; step;
    endtask
    task automatic enter5(input logic [3:0] a, b, c, d, e);
        press_ins(a); press_ins(b); press_ins(c); press_ins(d); press_ins(e);
    endtask
    // Finish edge plus one CHECK cycle elapse in press_fin; four more reach RESULT.
    task automatic submit;
        press_fin;
        repeat (4) step;
    endtask

    initial begin
        reset = 1'b0; num = 4'd0; insert = 1'b0; del = 1'b0; finish = 1'b0;
        #12;
        chk("rst_state",  32'(state), 32'd0);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_prize",  32'(prize), 32'd0);
        chk("rst_win",    32'(win), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        chk("rst_tries",  32'(tries_left), 32'd3);
        #10 reset = 1'b1;
        step;

        // Rejected inputs
        press_del;
        chk("del_empty_err", 32'(err_seen), 32'd1);
        chk("del_empty_cnt", 32'(count), 32'd0);
        press_ins(4'd12);
        chk("bad_num_err", 32'(err_seen), 32'd1);
        chk("bad_num_cnt", 32'(count), 32'd0);
        chk("err_one_cycle", 32'(err), 32'd0);
        press_ins(4'd5); press_ins(4'd0); press_ins(4'd9);
        chk("three_digits", 32'(digits), 32'h50900);
        press_fin;
        chk("fin_entry_err", 32'(err_seen), 32'd1);
        chk("fin_entry_st",  32'(state), 32'd0);

        // Deletion, simultaneous insert+del, del from READY
        press_del;
        chk("del_cnt", 32'(count), 32'd2);
        chk("del_dig", 32'(digits), 32'h50000);
        press_both(4'd3);
        chk("both_cnt", 32'(count), 32'd1);
        chk("both_dig", 32'(digits), 32'h50000);
        chk("both_err", 32'(err_seen), 32'd0);
        press_ins(4'd0); press_ins(4'd9); press_ins(4'd6); press_ins(4'd7);
        chk("ready_st",  32'(state), 32'd1);
        chk("ready_dig", 32'(digits), 32'h50967);
        press_ins(4'd1);
        chk("ins_full_cnt", 32'(count), 32'd5);
        press_del;
        chk("del_ready_st",  32'(state), 32'd0);
        chk("del_ready_dig", 32'(digits), 32'h50960);
        press_ins(4'd7);

        // Ticket 1: jackpot, with CHECK lasting exactly 5 cycles
        finish = 1'b1; step; finish = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("check_cyc%0d", i), 32'(state), 32'd2);
            if (i < 4) step;
        end
        step;
        chk("t1_state", 32'(state), 32'd3);
        chk("t1_prize", 32'(prize), 32'd1);
        chk("t1_win",   32'(win), 32'd1);
        chk("t1_tries", 32'(tries_left), 32'd2);
        press_ins(4'd2);
        chk("result_ins_err", 32'(err_seen), 32'd0);
        chk("result_ins_dig", 32'(digits), 32'h50967);
        press_fin;
        chk("ack_state",  32'(state), 32'd0);
        chk("ack_digits", 32'(digits), 32'h0);
        chk("ack_count",  32'(count), 32'd0);
        chk("ack_prize",  32'(prize), 32'd0);
        chk("ack_win",    32'(win), 32'd0);

        // Ticket 2: four hits -> second prize
        enter5(4'd5, 4'd0, 4'd9, 4'd6, 4'd1);
        submit;
        chk("t2_prize", 32'(prize), 32'd2);
        chk("t2_win",   32'(win), 32'd1);
        chk("t2_tries", 32'(tries_left), 32'd1);
        press_fin;

        // Ticket 3: three hits -> third prize, then lockout
        enter5(4'd5, 4'd0, 4'd1, 4'd1, 4'd7);
        submit;
        chk("t3_prize", 32'(prize), 32'd3);
        chk("t3_tries", 32'(tries_left), 32'd0);
        press_fin;
        chk("locked_st",    32'(state), 32'd4);
        chk("locked_tries", 32'(tries_left), 32'd0);
        press_ins(4'd4);
        chk("locked_ins_err", 32'(err_seen), 32'd1);
        chk("locked_ins_cnt", 32'(count), 32'd0);
        press_fin;
        chk("locked_fin_err", 32'(err_seen), 32'd1);
        chk("locked_fin_st",  32'(state), 32'd4);

        reset = 1'b0; #2;
        chk("unlock_st",    32'(state), 32'd0);
        chk("unlock_tries", 32'(tries_left), 32'd3);
        reset = 1'b1;
        step;

        // No hits -> no prize
        enter5(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        submit;
        chk("t4_state", 32'(state), 32'd3);
        chk("t4_prize", 32'(prize), 32'd0);
        chk("t4_win",   32'(win), 32'd0);
        chk("t4_tries", 32'(tries_left), 32'd2);
        press_fin;

        // Reset in the third CHECK cycle aborts at once
        enter5(4'd5, 4'd0, 4'd9, 4'd6, 4'd7);
        finish = 1'b1; step; finish = 1'b0;
        step; step;
        chk("mid_check_st", 32'(state), 32'd2);
        #2 reset = 1'b0; #1;
        chk("abort_state",  32'(state), 32'd0);
        chk("abort_digits", 32'(digits), 32'h0);
        chk("abort_count",  32'(count), 32'd0);
        chk("abort_prize",  32'(prize), 32'd0);
        chk("abort_win",    32'(win), 32'd0);
        chk("abort_tries",  32'(tries_left), 32'd3);
        num = 4'd8; insert = 1'b1;
        #10 reset = 1'b1;
        step; step; step;
        chk("held_ins_cnt", 32'(count), 32'd0);
        chk("held_ins_err", 32'(err), 32'd0);
        insert = 1'b0; step;
        press_ins(4'd8);
        chk("post_rel_cnt", 32'(count), 32'd1);
        chk("post_rel_dig", 32'(digits), 32'h80000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/loteria_n.md
LOTERIA_N -- requirements
Module: loteria_n

Interface
REQ-001 SHALL have parameter DIGITS, default 5, number of ticket digits (3..8).
REQ-002 SHALL have parameter SECRET, default 20'h50967, packed BCD winning number (4*DIGITS bits), most significant digit first.
REQ-003 SHALL have parameter MAX_TRIES, default 3, tickets allowed before lockout (1..15).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port num  in  4  BCD digit to enter.
REQ-007 SHALL have port insert  in  1  level input; a rising edge enters num.
REQ-008 SHALL have port del  in  1  level input; a rising edge removes the last entered digit.
REQ-009 SHALL have port finish  in  1  level input; a rising edge submits or acknowledges.
REQ-010 SHALL have port digits  out  4*DIGITS  entered digits, first entered digit in the MS nibble, unentered nibbles 0.
REQ-011 SHALL have port count  out  4  number of digits entered (0..DIGITS).
REQ-012 SHALL have port state  out  3  FSM state code.
REQ-013 SHALL have port prize  out  2  prize tier: 0 none, 1 jackpot, 2 second, 3 third.
REQ-014 SHALL have port win  out  1  high while prize != 0 is displayed.
REQ-015 SHALL have port err  out  1  one-cycle pulse on a rejected input.
REQ-016 SHALL have port tries_left  out  4  tickets remaining.

Function
REQ-017 SHALL register insert, del and finish once and act only on 0->1 edges; a held level SHALL act once.
REQ-018 SHALL implement states ENTRY=0, READY=1, CHECK=2, RESULT=3, LOCKED=4.
REQ-019 In ENTRY, an insert edge with num<=9 and count<DIGITS SHALL store num at position count and increment count; on reaching DIGITS the FSM SHALL go to READY.
REQ-020 An insert edge with num>9 SHALL be rejected with an err pulse and no other change.
REQ-021 A del edge in ENTRY or READY with count>0 SHALL clear the last digit and decrement count (READY->ENTRY); with count=0 it SHALL pulse err.
REQ-022 Simultaneous insert and del edges SHALL execute del only.
REQ-023 A finish edge in ENTRY SHALL pulse err and be ignored; in READY it SHALL go to CHECK and clear the hit counter.
REQ-024 CHECK SHALL compare one digit per cycle against SECRET, position 0 first, incrementing hits on equality; it SHALL last exactly DIGITS cycles, then go to RESULT.
REQ-025 On entering RESULT: prize=1 if hits=DIGITS, 2 if hits=DIGITS-1, 3 if hits=DIGITS-2, else 0; win=(prize!=0); tries_left decrements by 1.
REQ-026 All edges other than finish SHALL be ignored in CHECK and RESULT without err.
REQ-027 A finish edge in RESULT SHALL clear digits, count, prize and win, then go to ENTRY if tries_left>0, else to LOCKED.
REQ-028 LOCKED SHALL ignore all inputs except reset; any insert, del or finish edge there SHALL pulse err.
REQ-029 The hit counter SHALL be wide enough for DIGITS without wrap; tries_left SHALL never go below 0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=0: state=ENTRY, digits=0, count=0, prize=0, win=0, err=0, tries_left=MAX_TRIES, edge registers=0.
REQ-032 Reset asserted mid-CHECK or mid-RESULT SHALL abort immediately with no prize latched.
REQ-033 A level held high through reset release SHALL NOT be treated as an edge.

Verification (DIGITS=5, SECRET=50967, MAX_TRIES=3)
REQ-034 Enter 5,0,9,6,7, then finish -> CHECK for 5 cycles, then RESULT with prize=1, win=1, tries_left=2.
REQ-035 Enter 5,0,9,6,1, then finish -> prize=2; enter 5,0,1,1,7 -> prize=3; enter 1,2,3,4,5 -> prize=0, win=0.
REQ-036 Insert num=12 -> err for 1 cycle, count unchanged; finish at count=3 -> err; del at count=0 -> err.
REQ-037 Enter 5,0,9, del, 9, 6, 7, finish -> digits=0x50967, prize=1; simultaneous insert+del -> count decrements only.
REQ-038 Run 3 tickets, then finish in RESULT -> state=LOCKED, tries_left=0; insert -> err; reset -> ENTRY, tries_left=3.
REQ-039 Assert reset on the 3rd CHECK cycle -> all outputs immediately at reset values; hold insert high across release -> no digit entered.
